// File: rtl/sort_pkg.sv
// Shared constants for the nibble sort sequencer: state encoding and datapath widths.
package sort_pkg;

    localparam int unsigned ELEM_W = 4;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/comp4.sv
// Unsigned 4-bit comparator: eq when a == b, lt when a < b.
module comp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       eq,
    output logic       lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/nibble_sort_ctrl.sv
// Bubble-sort sequencer for N nibbles, one compare-and-swap per clock through a shared comp4.
// Define SORT_EARLY_EXIT_EN to finish as soon as a full pass makes no swaps.
module nibble_sort_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ELEM_W*N-1:0]   data_in,
    output logic                  busy,
    output logic                  done,
    output logic [ELEM_W*N-1:0]   data_out,
    output logic [CNT_W-1:0]      swap_count
);

    localparam int unsigned IDX_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 2);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             j_q, j_d;
    logic [IDX_W-1:0]             pass_q, pass_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [N-1:0][ELEM_W-1:0]     work_q, work_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [ELEM_W*N-1:0]          dout_q, dout_d;
    logic [CNT_W-1:0]             swaps_q, swaps_d;
`ifdef SORT_EARLY_EXIT_EN
    logic                         swapped_q, swapped_d;
`endif

    logic [IDX_W-1:0]             jn;
    logic                         cmp_eq;
    logic                         cmp_lt;
    logic                         do_swap;
    logic                         last_pass;

    assign jn = j_q + IDX_W'(1);

    // Comparator a is the upper element of the pair, so lt means the pair is out of order.
    comp4 u_comp4 (
        .a  (work_q[jn]),
        .b  (work_q[j_q]),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    assign do_swap = cmp_lt & ~cmp_eq;

    // Next-state, datapath and output logic.
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        dout_d    = dout_q;
        swaps_d   = swaps_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        last_pass = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = data_in;
                    j_d     = '0;
                    pass_d  = '0;
                    cnt_d   = '0;
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
`endif
                    state_d = SORT;
                end
            end
            SORT: begin
                if (do_swap) begin
                    work_d[j_q] = work_q[jn];
                    work_d[jn]  = work_q[j_q];
                    cnt_d       = cnt_q + CNT_W'(1);
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d   = 1'b1;
`endif
                end
                if (j_q == LAST) begin
                    j_d       = '0;
                    pass_d    = pass_q + IDX_W'(1);
                    last_pass = (pass_q == LAST);
`ifdef SORT_EARLY_EXIT_EN
                    last_pass = last_pass | ~(swapped_q | do_swap);
                    swapped_d = 1'b0;
`endif
                    // Publish the result on entry so it is visible alongside done.
                    if (last_pass) begin
                        dout_d  = work_d;
                        swaps_d = cnt_d;
                        state_d = DONE;
                    end
                end else begin
                    j_d = jn;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            j_q       <= '0;
            pass_q    <= '0;
            cnt_q     <= '0;
            work_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            swaps_q   <= '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
            swaps_q   <= swaps_d;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q <= swapped_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = dout_q;
    assign swap_count = swaps_q;

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Scoreboard bench for nibble_sort_ctrl (N=4 main instance plus an N=2 instance).
// Expected latency follows SORT_EARLY_EXIT_EN when the bench is built with it.
module tb_nibble_sort_ctrl;

    localparam int unsigned N       = 4;
    localparam int          NI      = 4;
    localparam int unsigned W       = 4 * N;
    localparam int          TIMEOUT = 100;
`ifdef SORT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   data_in;
    logic           busy;
    logic           done;
    logic [W-1:0]   data_out;
    logic [5:0]     swap_count;

    logic           start2;
    logic [7:0]     data_in2;
    logic           busy2;
    logic           done2;
    logic [7:0]     data_out2;
    logic [5:0]     swap_count2;

    typedef struct {
        logic [W-1:0] data;
        logic [5:0]   cnt;
        int           lat;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  sb2[$];
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    nibble_sort_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .swap_count (swap_count)
    );

    nibble_sort_ctrl #(.N(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .data_in    (data_in2),
        .busy       (busy2),
        .done       (done2),
        .data_out   (data_out2),
        .swap_count (swap_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference bubble sort: full-length passes, counting swaps and passes that swapped.
    function automatic exp_t model(input logic [W-1:0] d);
        exp_t       e;
        logic [3:0] el [N];
        logic [3:0] t;
        int         active;
        int         passes;
        bit         sw;
        for (int k = 0; k < NI; k++) el[k] = d[4*k +: 4];
        e.cnt  = 6'd0;
        active = 0;
        for (int p = 0; p < NI - 1; p++) begin
            sw = 1'b0;
            for (int j = 0; j < NI - 1; j++) begin
                if (el[j+1] < el[j]) begin
                    t       = el[j];
                    el[j]   = el[j+1];
                    el[j+1] = t;
                    e.cnt   = e.cnt + 6'd1;
                    sw      = 1'b1;
                end
            end
            if (sw) active = p + 1;
        end
        for (int k = 0; k < NI; k++) e.data[4*k +: 4] = el[k];
        passes = EARLY ? ((active + 1 < NI - 1) ? active + 1 : NI - 1) : NI - 1;
        e.lat  = passes * (NI - 1) + 1;
        return e;
    endfunction

    // Start one sort at cycle 0, follow it to done, then check the idle cycle after.
    task automatic run_sort(input logic [W-1:0] d, input string name);
        exp_t         e;
        int           cyc;
        bit           seen;
        logic [W-1:0] held;
        sb.push_back(model(d));
        data_in = d;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_in = ~d;
        cyc     = 1;
        seen    = 1'b0;
        while (!seen && cyc < TIMEOUT) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy at cycle %0d: got %b want 1", name, cyc, busy);
                end
                tick();
                cyc++;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s timeout: no done within %0d cycles", name, TIMEOUT);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        vectors += 4;
        if (cyc !== e.lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
        end
        if (data_out !== e.data) begin
            miscompares++;
            $display("FAIL %s data_out: got %h want %h", name, data_out, e.data);
        end
        if (swap_count !== e.cnt) begin
            miscompares++;
            $display("FAIL %s swap_count: got %0d want %0d", name, swap_count, e.cnt);
        end
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy in done cycle: got %b want 1", name, busy);
        end
        held = data_out;
        tick();
        vectors += 3;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done pulse width: got %b want 0", name, done);
        end
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy after done: got %b want 0", name, busy);
        end
        if (data_out !== held) begin
            miscompares++;
            $display("FAIL %s data_out hold: got %h want %h", name, data_out, held);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        start2   = 1'b0;
        data_in  = 16'hFFFF;
        data_in2 = 8'hFF;
        repeat (2) tick();
        vectors += 5;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset busy: got %b want 0", busy);
        end
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset done: got %b want 0", done);
        end
        if (data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset data_out: got %h want 0000", data_out);
        end
        if (swap_count !== 6'd0) begin
            miscompares++;
            $display("FAIL reset swap_count: got %0d want 0", swap_count);
        end
        if (busy2 !== 1'b0 || data_out2 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset n2: got busy=%b data_out=%h want 0/00", busy2, data_out2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sorted();
        run_sort(16'h4321, "sorted");
    endtask

    task automatic test_reversed();
        run_sort(16'h05AF, "reversed");
    endtask

    task automatic test_duplicates();
        run_sort(16'h3737, "duplicates");
    endtask

    // Starts during SORT (cycle 3) and DONE (cycle 10) are dropped; cycle 11 is accepted.
    task automatic test_ignore_start();
        exp_t e;
        int   cyc;
        bit   seen;
        sb.push_back(model(16'h05AF));
        data_in = 16'h05AF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (2) tick();
        start   = 1'b1;
        data_in = 16'h3333;
        tick();
        start   = 1'b0;
        repeat (6) tick();
        e = sb.pop_front();
        vectors += 2;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore done at cycle 10: got %b want 1", done);
        end
        if (data_out !== e.data || swap_count !== e.cnt) begin
            miscompares++;
            $display("FAIL ignore first result: got %h/%0d want %h/%0d", data_out, swap_count, e.data, e.cnt);
        end
        sb.push_back(model(16'h1234));
        start   = 1'b1;
        data_in = 16'h1234;
        tick();
        vectors += 2;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore cycle 11: got busy=%b done=%b want 0/0", busy, done);
        end
        if (data_out !== e.data) begin
            miscompares++;
            $display("FAIL ignore hold: got %h want %h", data_out, e.data);
        end
        tick();
        start   = 1'b0;
        data_in = 16'hFFFF;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore accept at cycle 11: got busy=%b want 1", busy);
        end
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < TIMEOUT) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        e = sb.pop_front();
        vectors++;
        if (!seen || cyc !== e.lat || data_out !== e.data || swap_count !== e.cnt) begin
            miscompares++;
            $display("FAIL ignore second sort: got lat=%0d %h/%0d want lat=%0d %h/%0d",
                     cyc, data_out, swap_count, e.lat, e.data, e.cnt);
        end
        tick();
    endtask

    task automatic test_rst_midsort();
        data_in = 16'h1F2E;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors += 4;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset busy: got %b want 0", busy);
        end
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset done: got %b want 0", done);
        end
        if (data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset data_out: got %h want 0000", data_out);
        end
        if (swap_count !== 6'd0) begin
            miscompares++;
            $display("FAIL midreset swap_count: got %0d want 0", swap_count);
        end
        run_sort(16'h9C2E, "after_reset");
    endtask

    task automatic test_n2();
        sb2.push_back(8'h94);
        data_in2 = 8'h49;
        start2   = 1'b1;
        tick();
        start2   = 1'b0;
        vectors++;
        if (busy2 !== 1'b1 || done2 !== 1'b0) begin
            miscompares++;
            $display("FAIL n2 cycle 1: got busy=%b done=%b want 1/0", busy2, done2);
        end
        tick();
        vectors += 3;
        if (done2 !== 1'b1) begin
            miscompares++;
            $display("FAIL n2 done at cycle 2: got %b want 1", done2);
        end
        if (data_out2 !== sb2.pop_front()) begin
            miscompares++;
            $display("FAIL n2 data_out: got %h want 94", data_out2);
        end
        if (swap_count2 !== 6'd1) begin
            miscompares++;
            $display("FAIL n2 swap_count: got %0d want 1", swap_count2);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_sort(W'($urandom), "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_sorted();
        test_reversed();
        test_duplicates();
        test_ignore_start();
        test_rst_midsort();
        test_n2();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
